nibble_serial_sub: RTL and testbench
====================================

NIBBLE_SERIAL_SUB -- requirements
Module: nibble_serial_sub

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` (input, 1, rising-edge clock) and `rst` (input, 1, synchronous active-high reset).
REQ-002 Port `start` SHALL be an input, 1 bit: request a subtraction; sampled on rising `clk`.
REQ-003 Port `A` SHALL be an input, 16 bits: minuend; captured when `start` is accepted.
REQ-004 Port `B` SHALL be an input, 16 bits: subtrahend; captured when `start` is accepted.
REQ-005 Port `busy` SHALL be an output, 1 bit: high while a subtraction is in progress.
REQ-006 Port `done` SHALL be an output, 1 bit: one-cycle pulse when the result is valid.
REQ-007 Port `Diff` SHALL be an output, 16 bits: result A-B, or the saturated result when SAT_EN is defined.
REQ-008 Port `Bout` SHALL be an output, 1 bit: unsigned borrow out (1 when A<B unsigned).
REQ-009 Port `Ovfl` SHALL be an output, 1 bit: signed two's-complement overflow of A-B.
REQ-010 Port `Zero` SHALL be an output, 1 bit: 1 when the final `Diff` equals 0x0000.

Function
REQ-011 The block SHALL implement states IDLE, RUN and DONE.
REQ-012 In IDLE with `start`=1, the block SHALL capture A and ~B, set borrow-in carry=1, clear the nibble index to 0 and go to RUN.
REQ-013 In RUN, the block SHALL process one 4-bit nibble per cycle, LSB nibble first, as A[n] + ~B[n] + carry.
- The nibble sum SHALL be written to the result register.
- The nibble carry-out SHALL be stored for the next nibble.
REQ-014 RUN SHALL last exactly 4 cycles (index 0..3); after index 3 the block SHALL go to DONE.
REQ-015 Latency: for `start` accepted at edge k, `done` SHALL be high for exactly one cycle, in the cycle following edge k+5.
REQ-016 `busy` SHALL be high from the cycle after acceptance through the last RUN cycle, and low in IDLE and DONE.
REQ-017 Result flags SHALL be computed from the full 16-bit operation:
- `Bout` = NOT(final carry).
- `Ovfl` = (A[15] != B[15]) AND (raw result[15] != A[15]).
REQ-018 `Diff`, `Bout`, `Ovfl` and `Zero` SHALL be updated only when entering DONE, and SHALL hold until the next result is produced.
REQ-019 `start` while `busy`=1 SHALL be ignored, with no effect on the operands or the sequence in flight.
REQ-020 DONE SHALL return to IDLE after one cycle.
- If `start`=1 in the DONE cycle, it SHALL be accepted and the block SHALL go directly to RUN (back-to-back throughput of one result per 5 cycles).
REQ-021 A or B changing after acceptance SHALL NOT affect the result in flight.

Reset
REQ-022 `rst`=1 at a rising edge SHALL force IDLE and clear all outputs to 0: `busy`, `done`, `Diff`=0x0000, `Bout`, `Ovfl`.
- `Zero` SHALL reset to 1, consistent with `Diff`=0.
REQ-023 Reset mid-RUN SHALL abort the operation: no `done` pulse, and the previous result SHALL be discarded.
REQ-024 Reset SHALL take priority over `start` in the same cycle.

Configuration
REQ-025 When the macro SAT_EN is defined and `Ovfl`=1:
- `Diff` SHALL be clamped to 0x7FFF if A[15]=0, and to 0x8000 if A[15]=1.
- `Zero` SHALL be evaluated after clamping.
REQ-026 When SAT_EN is not defined, `Diff` SHALL be the raw 16-bit wrap-around result.
REQ-027 `Ovfl` and `Bout` SHALL be identical in both configurations.

Verification
REQ-028 A=0x1234, B=0x0234, start -> `done` after 5 cycles with Diff=0x1000, Bout=0, Ovfl=0, Zero=0.
REQ-029 A=0x0000, B=0x0001 -> Diff=0xFFFF, Bout=1, Ovfl=0.
- A=0x5A5A, B=0x5A5A -> Diff=0x0000, Zero=1.
REQ-030 A=0x7FFF, B=0xFFFF -> Ovfl=1; Diff=0x8000 without SAT_EN, 0x7FFF with SAT_EN.
- A=0x8000, B=0x0001 -> Ovfl=1, Bout=0; Diff=0x7FFF without SAT_EN, 0x8000 with SAT_EN.
REQ-031 `start` pulsed at acceptance+2 with new operands -> ignored; the first result is unchanged.
- `start` held high during the DONE cycle -> second result arrives 5 cycles after the first `done`.
REQ-032 `rst` asserted 2 cycles into RUN -> no `done`, busy=0, Diff=0x0000, Zero=1 the next cycle.
- A fresh start afterwards -> correct result.

Source files
------------

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: 16-bit A-B computed one nibble per cycle as A + ~B + 1.
// Optional macro SAT_EN clamps Diff to 0x7FFF/0x8000 on signed overflow.
module nibble_serial_sub (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Diff,
  output logic        Bout,
  output logic        Ovfl,
  output logic        Zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  idx_r;
  logic        carry_r;
  logic [15:0] a_r;
  logic [15:0] nb_r;
  logic [11:0] res_r;
  logic        busy_r;
  logic        done_r;
  logic [15:0] diff_r;
  logic        bout_r;
  logic        ovfl_r;
  logic        zero_r;

  logic        accept_s;
  logic [3:0]  nib_a_s;
  logic [3:0]  nib_b_s;
  logic [4:0]  sum_s;
  logic [15:0] raw_s;
  logic        ovfl_s;
  logic        bout_s;
  logic [15:0] diff_next_s;
  logic        zero_next_s;

  function automatic logic [4:0] nibble_add(input logic [3:0] x, input logic [3:0] y,
                                            input logic cin);
    nibble_add = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
  endfunction

  function automatic logic [15:0] saturate(input logic [15:0] raw, input logic ovf,
                                           input logic a_msb);
    if (!ovf) begin
      saturate = raw;
    end else if (a_msb) begin
      saturate = 16'h8000;
    end else begin
      saturate = 16'h7FFF;
    end
  endfunction

  // Nibble datapath and final-result flags; raw_s is only meaningful at index 3.
  always_comb begin
    accept_s = 1'b0;
    if (start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    nib_a_s = a_r[{idx_r, 2'b00} +: 4];
    nib_b_s = nb_r[{idx_r, 2'b00} +: 4];
    sum_s   = nibble_add(nib_a_s, nib_b_s, carry_r);
    raw_s   = {sum_s[3:0], res_r};
    bout_s  = ~sum_s[4];
    // nb_r holds ~B, so B[15] is the inverse of nb_r[15]
    ovfl_s  = (a_r[15] != ~nb_r[15]) && (raw_s[15] != a_r[15]);
`ifdef SAT_EN
    diff_next_s = saturate(raw_s, ovfl_s, a_r[15]);
`else
    diff_next_s = raw_s;
`endif
    zero_next_s = (diff_next_s == 16'h0000);
  end

  // Sequencer, operand capture, nibble accumulation and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 2'd0;
      carry_r <= 1'b0;
      a_r     <= 16'h0000;
      nb_r    <= 16'h0000;
      res_r   <= 12'h000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      diff_r  <= 16'h0000;
      bout_r  <= 1'b0;
      ovfl_r  <= 1'b0;
      zero_r  <= 1'b1;
    end else begin
      if (accept_s) begin
        a_r     <= A;
        nb_r    <= ~B;
        carry_r <= 1'b1;
        idx_r   <= 2'd0;
      end
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          done_r  <= 1'b0;
          carry_r <= sum_s[4];
          idx_r   <= idx_r + 2'd1;
          case (idx_r)
            2'd0:    res_r[3:0]  <= sum_s[3:0];
            2'd1:    res_r[7:4]  <= sum_s[3:0];
            2'd2:    res_r[11:8] <= sum_s[3:0];
            default: res_r       <= res_r;
          endcase
          if (idx_r == 2'd3) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            diff_r  <= diff_next_s;
            bout_r  <= bout_s;
            ovfl_r  <= ovfl_s;
            zero_r  <= zero_next_s;
          end
        end
        ST_DONE: begin
          done_r <= 1'b1;
          if (accept_s) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign Diff = diff_r;
  assign Bout = bout_r;
  assign Ovfl = ovfl_r;
  assign Zero = zero_r;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub: arithmetic reference model, queued
// expectations, and a negedge monitor that checks every done pulse.
module tb_nibble_serial_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [15:0] B = 16'h0000;
  logic        busy, done, Bout, Ovfl, Zero;
  logic [15:0] Diff;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        ovfl;
    logic        zero;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  nibble_serial_sub dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .Ovfl(Ovfl), .Zero(Zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   sa, sb, d;
    sa = int'($signed(a));
    sb = int'($signed(b));
    d  = sa - sb;
    e.diff = a - b;
    e.bout = (a < b);
    e.ovfl = (d > 32767) || (d < -32768);
`ifdef SAT_EN
    if (d > 32767) e.diff = 16'h7FFF;
    if (d < -32768) e.diff = 16'h8000;
`endif
    e.zero = (e.diff == 16'h0000);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("diff", {16'h0000, Diff}, {16'h0000, e.diff});
        chk("bout", {31'd0, Bout}, {31'd0, e.bout});
        chk("ovfl", {31'd0, Ovfl}, {31'd0, e.ovfl});
        chk("zero", {31'd0, Zero}, {31'd0, e.zero});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one operation at a negedge while the DUT is ready; returns at the
  // DONE-cycle negedge plus gap cycles. inject pulses an ignored start mid-RUN.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input bit inject, input int gap);
    exp_t e;
    e = model(a, b);
    e.cyc = cyc + 6;
    exp_q.push_back(e);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
    chk("busy_run", {31'd0, busy}, 32'd1);
    @(negedge clk);
    if (inject) begin
      start = 1'b1; A = 16'($urandom); B = 16'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_done_state", {31'd0, busy}, 32'd0);
    repeat (gap) @(negedge clk);
  endtask

  logic [15:0] vec_a [6] = '{16'h1234, 16'h0000, 16'h5A5A, 16'h7FFF, 16'h8000, 16'hFFFF};
  logic [15:0] vec_b [6] = '{16'h0234, 16'h0001, 16'h5A5A, 16'hFFFF, 16'h0001, 16'hFFFF};

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {16'h0000, Diff}, 32'd0);
    chk("rst_bout", {31'd0, Bout}, 32'd0);
    chk("rst_ovfl", {31'd0, Ovfl}, 32'd0);
    chk("rst_zero", {31'd0, Zero}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) issue(vec_a[i], vec_b[i], 1'b0, 2);
    issue(16'h4321, 16'h1111, 1'b1, 3);
    // Back-to-back: second start lands in the DONE cycle.
    issue(16'hABCD, 16'h1234, 1'b0, 0);
    issue(16'h0F0F, 16'hF0F0, 1'b0, 0);
    issue(16'h8000, 16'h7FFF, 1'b0, 1);

    // Abort two cycles into RUN.
    A = 16'h9999; B = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_diff", {16'h0000, Diff}, 32'd0);
    chk("abort_zero", {31'd0, Zero}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (8) @(negedge clk);
    issue(16'h1000, 16'h0001, 1'b0, 1);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; A = 16'h2222; B = 16'h1111;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: ra = {1'b0, ra[14:0]};
        default: ;
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
